// File: rtl/alu_seq.sv
// alu_seq: registered four-group ALU (arith/shift/compare/logic) with valid/ready handshake
// and an N-cycle shift-add multiplier. Define ALU_SEQ_FLAGS_EN to add the flags output.
module alu_seq #(
  parameter int unsigned N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   x,
  input  logic [N-1:0]   y,
  input  logic [1:0]     m,
  input  logic [1:0]     s,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] z
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic [3:0]     flags
`endif
);

  localparam int unsigned ZW = 2 * N;
  localparam int unsigned LW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [ZW-1:0] z_q, z_d;
  logic [ZW-1:0] acc_q, acc_d;
  logic [ZW-1:0] mcand_q, mcand_d;
  logic [N-1:0]  mplier_q, mplier_d;
  logic [LW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  lo_c;
  logic [ZW-1:0] res_c;
  logic [ZW-1:0] rotl_w, rotr_w;
  logic [LW-1:0] rot_amt;
  logic          big_shift;
  logic          is_mul_c;
  logic          accept_c;
  logic [ZW-1:0] acc_sum_c;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept_c  = in_valid && in_ready;
  assign is_mul_c  = (s == 2'b00) && (m == 2'b10);
  assign acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign out_valid = (state_q == DONE);
  assign z         = z_q;

  // Single-cycle result for every op except multiply; rotates use a doubled operand.
  always_comb begin
    rot_amt   = y[LW-1:0];
    rotl_w    = {x, x} << rot_amt;
    rotr_w    = {x, x} >> rot_amt;
    big_shift = (y >= N'(N));
    lo_c      = '0;
    res_c     = '0;
    case (s)
      2'b00: begin
        case (m)
          2'b00:   res_c = ZW'(x) + ZW'(y);
          2'b01:   res_c = ZW'(x) - ZW'(y);
          2'b11:   res_c = ZW'(x) + ZW'(1);
          default: res_c = '0;
        endcase
      end
      2'b01: begin
        case (m)
          2'b00:   lo_c = big_shift ? '0 : (x << y);
          2'b01:   lo_c = big_shift ? '0 : (x >> y);
          2'b10:   lo_c = rotl_w[ZW-1:N];
          default: lo_c = rotr_w[N-1:0];
        endcase
        res_c = ZW'(lo_c);
      end
      2'b10: begin
        case (m)
          2'b00:   res_c = ZW'(x == y);
          2'b01:   res_c = ZW'(x < y);
          2'b10:   res_c = ZW'(x > y);
          default: res_c = ZW'($signed(x) < $signed(y));
        endcase
      end
      default: begin
        case (m)
          2'b00:   lo_c = x & y;
          2'b01:   lo_c = x | y;
          2'b10:   lo_c = x ^ y;
          default: lo_c = ~x;
        endcase
        res_c = ZW'(lo_c);
      end
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0] flags_q, flags_d;
  logic [3:0] flg_c;

  // {zero, carry, overflow, negative} for single-cycle ops.
  always_comb begin
    flg_c = '0;
    if (s == 2'b00) begin
      case (m)
        2'b00: begin
          flg_c[2] = res_c[N];
          flg_c[1] = (x[N-1] == y[N-1]) && (res_c[N-1] != x[N-1]);
        end
        2'b01: begin
          flg_c[2] = (x < y);
          flg_c[1] = (x[N-1] != y[N-1]) && (res_c[N-1] != x[N-1]);
        end
        2'b11: begin
          flg_c[2] = res_c[N];
          flg_c[1] = !x[N-1] && res_c[N-1];
        end
        default: flg_c[2:1] = 2'b00;
      endcase
    end
    flg_c[3] = (res_c == '0);
    flg_c[0] = res_c[N-1];
  end

  assign flags = flags_q;
`endif

  // Next-state, handshake and multiplier sequencing.
  always_comb begin
    state_d  = state_q;
    z_d      = z_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`ifdef ALU_SEQ_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (accept_c) begin
          if (is_mul_c) begin
            acc_d    = '0;
            mcand_d  = ZW'(x);
            mplier_d = y;
            cnt_d    = '0;
            state_d  = BUSY;
          end else begin
            z_d     = res_c;
`ifdef ALU_SEQ_FLAGS_EN
            flags_d = flg_c;
`endif
            state_d = DONE;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d    = acc_sum_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + LW'(1);
        if (cnt_q == LW'(N - 1)) begin
          z_d     = acc_sum_c;
`ifdef ALU_SEQ_FLAGS_EN
          flags_d = {(acc_sum_c == '0), 1'b0, 1'b0, acc_sum_c[N-1]};
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      z_q      <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      z_q      <= z_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (N=8): directed cases, randomized ops against an
// arithmetic reference model, back-to-back, backpressure and mid-multiply reset.
module tb_alu_seq;

  localparam int N    = 8;
  localparam int ZW   = 2 * N;
  localparam int MASK = (1 << N) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic [1:0]    m;
  logic [1:0]    s;
  logic          out_valid;
  logic          out_ready;
  logic [ZW-1:0] z;
`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0]    flags;
`endif

  int n_checks;
  int n_fail;

  alu_seq #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .m         (m),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int sx(input int v);
    return (v >= (1 << (N - 1))) ? v - (1 << N) : v;
  endfunction

  // Reference result from the op definitions using plain integer arithmetic.
  function automatic int ref_z(input int a, input int b, input int mm, input int ss);
    int k;
    int r;
    r = 0;
    k = b % N;
    case (ss)
      0: case (mm)
           0: r = a + b;
           1: r = (a - b) & 'hFFFF;
           2: r = a * b;
           default: r = a + 1;
         endcase
      1: case (mm)
           0: r = (b >= N) ? 0 : ((a << b) & MASK);
           1: r = (b >= N) ? 0 : (a >> b);
           2: r = ((a << k) | (a >> (N - k))) & MASK;
           default: r = ((a >> k) | (a << (N - k))) & MASK;
         endcase
      2: case (mm)
           0: r = (a == b) ? 1 : 0;
           1: r = (a < b) ? 1 : 0;
           2: r = (a > b) ? 1 : 0;
           default: r = (sx(a) < sx(b)) ? 1 : 0;
         endcase
      default: case (mm)
           0: r = a & b;
           1: r = a | b;
           2: r = a ^ b;
           default: r = (~a) & MASK;
         endcase
    endcase
    return r;
  endfunction

  function automatic int ref_flags(input int a, input int b, input int mm, input int ss);
    int r;
    int t;
    int zf;
    int cf;
    int vf;
    int nf;
    r  = ref_z(a, b, mm, ss);
    zf = (r == 0) ? 1 : 0;
    nf = (r >> (N - 1)) & 1;
    cf = 0;
    vf = 0;
    if (ss == 0) begin
      case (mm)
        0: begin cf = (r >> N) & 1; t = sx(a) + sx(b); end
        1: begin cf = (a < b) ? 1 : 0; t = sx(a) - sx(b); end
        3: begin cf = (r >> N) & 1; t = sx(a) + 1; end
        default: t = 0;
      endcase
      vf = (t > (1 << (N - 1)) - 1 || t < -(1 << (N - 1))) ? 1 : 0;
    end
    return (zf << 3) | (cf << 2) | (vf << 1) | nf;
  endfunction

  // Issue one op from IDLE, optionally pulsing in_valid while busy, and check its result.
  task automatic run_op(input int a, input int b, input int mm, input int ss,
                        input int exp_z, input bit pulse, input string tag);
    int lat;
    int exp_lat;
    bit got;
    exp_lat = (ss == 0 && mm == 2) ? N + 1 : 1;
    @(negedge clk);
    check_eq({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    x = N'(a); y = N'(b); m = 2'(mm); s = 2'(ss);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      x = N'($urandom); y = N'($urandom); m = 2'($urandom); s = 2'($urandom);
      if (out_valid) begin
        got = 1'b1;
        in_valid = 1'b0;
      end else begin
        check_eq({tag, "/busy_in_ready"}, 32'(in_ready), 32'd0);
        in_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    in_valid = 1'b0;
    check_eq({tag, "/latency"}, lat, exp_lat);
    check_eq({tag, "/z"}, 32'(z), 32'(exp_z));
`ifdef ALU_SEQ_FLAGS_EN
    check_eq({tag, "/flags"}, 32'(flags), 32'(ref_flags(a, b, mm, ss)));
`endif
    @(negedge clk);
    check_eq({tag, "/idle_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "/idle_z_hold"}, 32'(z), 32'(exp_z));
  endtask

  initial begin
    int a;
    int b;
    int mm;
    int ss;
    int exp_q[$];
    bool_t_dummy: begin end
  end

  initial begin
    int a;
    int b;
    int mm;
    int ss;
    int stale;
    int exp_arr[20];
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x = '0; y = '0; m = '0; s = '0;
    repeat (2) @(negedge clk);
    check_eq("reset/z", 32'(z), 32'd0);
    check_eq("reset/out_valid", 32'(out_valid), 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
    check_eq("reset/flags", 32'(flags), 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    check_eq("reset/in_ready", 32'(in_ready), 32'd1);

    run_op('hFF, 'h01, 0, 0, 'h0100, 1'b0, "add_ff_01");
    run_op(3, 5, 1, 0, 'hFFFE, 1'b0, "sub_3_5");
    run_op('h80, 'h01, 3, 2, 'h0001, 1'b0, "slt_80_01");
    run_op('h5A, 'h5A, 0, 2, 'h0001, 1'b0, "eq_5a");
    run_op(200, 200, 2, 0, 'h9C40, 1'b1, "mul_200_200");
    run_op(0, 'hA5, 2, 0, 'h0000, 1'b1, "mul_zero");
    run_op('h81, 1, 2, 1, 'h0003, 1'b0, "rotl_81_1");
    run_op('h01, 9, 0, 1, 'h0000, 1'b0, "sll_01_9");
    run_op('h01, 9, 3, 1, 'h0080, 1'b0, "rotr_01_9");
    run_op('h7F, 0, 3, 0, 'h0080, 1'b0, "inc_7f");
    run_op('hF0, 'h3C, 3, 3, 'h000F, 1'b0, "not_f0");

    for (int i = 0; i < 60; i++) begin
      ss = $urandom_range(0, 3);
      mm = $urandom_range(0, 3);
      a  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, MASK);
      b  = (ss == 1 && $urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : $urandom_range(0, MASK);
      run_op(a, b, mm, ss, ref_z(a, b, mm, ss), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // Back-to-back non-multiply stream at one op per cycle.
    out_ready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq($sformatf("b2b%0d/out_valid", i - 1), 32'(out_valid), 32'd1);
        check_eq($sformatf("b2b%0d/z", i - 1), 32'(z), 32'(exp_arr[i - 1]));
        check_eq($sformatf("b2b%0d/in_ready", i - 1), 32'(in_ready), 32'd1);
      end
      if (i < 20) begin
        ss = $urandom_range(0, 3);
        mm = $urandom_range(0, 3);
        if (ss == 0 && mm == 2) mm = 3;
        a = $urandom_range(0, MASK);
        b = $urandom_range(0, MASK);
        exp_arr[i] = ref_z(a, b, mm, ss);
        x = N'(a); y = N'(b); m = 2'(mm); s = 2'(ss);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);

    // Backpressure: hold the result while a new op waits.
    x = 'h12; y = 'h34; m = 2'd0; s = 2'd0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    x = 'h0F; y = 'hF0; m = 2'd2; s = 2'd3;
    check_eq("bp/first_z", 32'(z), 32'h46);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("bp%0d/z_stable", i), 32'(z), 32'h46);
      check_eq($sformatf("bp%0d/in_ready", i), 32'(in_ready), 32'd0);
      check_eq($sformatf("bp%0d/out_valid", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp/release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp/new_valid", 32'(out_valid), 32'd1);
    check_eq("bp/new_z", 32'(z), 32'h00FF);
    @(negedge clk);

    // Reset in the middle of a multiply must discard it.
    x = 8'd200; y = 8'd200; m = 2'd2; s = 2'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mul/z", 32'(z), 32'd0);
    check_eq("rst_mul/out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_mul/in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check_eq("rst_mul/no_stale", stale, 0);
    check_eq("rst_mul/z_after", 32'(z), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit combinational ALU.
- Same four operation groups, selected by s: arithmetic, shift/rotate, comparator and logic. m selects the op within each group.
- Operand width is N; result width is 2N.
- Adds a valid/ready handshake, a registered output, and a multi-cycle shift-add unsigned multiplier.
- Sits between the datapath register file and the writeback stage.

Parameters:
- N, 8: operand width. Must be a power of two, 4 or more. Result width is 2N.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block can accept an operation this cycle
- x  input  N  operand A
- y  input  N  operand B; for shifts/rotates, the shift amount
- m  input  2  op select within group
- s  input  2  group select: 00 arith, 01 shift/rotate, 10 compare, 11 logic
- out_valid  output  1  z holds a result
- out_ready  input  1  consumer takes the result
- z  output  2N  result

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; z=0; out_valid=0; multiplier registers cleared.
  - in_ready=1 once rst_n is released.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: multiply in progress; in_ready=0, out_valid=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Accept: an operation is accepted when in_valid && in_ready. x, y, m and s are captured on that edge; later input changes are ignored.
- Transitions:
  - IDLE, accept non-multiply -> DONE next cycle. Latency 1.
  - IDLE, accept multiply -> BUSY for N cycles -> DONE. out_valid rises N+1 cycles after the accept edge.
  - DONE && out_ready && !in_valid -> IDLE.
  - DONE && out_ready && in_valid -> accept the new operation. Back-to-back throughput: one non-multiply op per cycle.
  - DONE && !out_ready -> hold. z is stable; the new operation is not accepted.
- Arithmetic group (s=00). x and y are unsigned and zero-extended to 2N.
  - m=00: z=x+y; the carry lands in bit N.
  - m=01: z=x-y, computed modulo 2^2N (two's complement).
  - m=10: z=x*y, unsigned. Shift-add, one partial product per cycle, N cycles.
  - m=11: z=x+1.
- Shift/rotate group (s=01). Result in the low N bits, upper N bits 0.
  - m=00: shift left logical by y.
  - m=01: shift right logical by y.
  - For both shifts, y>=N gives 0.
  - m=10: rotate left by y mod N.
  - m=11: rotate right by y mod N.
- Compare group (s=10). z={0..., bit}.
  - m=00: x==y.
  - m=01: x<y, unsigned.
  - m=10: x>y, unsigned.
  - m=11: x<y, signed.
- Logic group (s=11). Result in the low N bits, upper N bits 0.
  - m=00: AND. m=01: OR. m=10: XOR. m=11: NOT x.
- Boundaries:
  - Reset during BUSY or DONE aborts the operation. No out_valid is produced for it.
  - in_valid while BUSY is ignored; no accept occurs.
  - z is updated only on entry to DONE. It holds its last value in IDLE.
  - Multiply of 0 still takes N cycles (fixed latency).

Optional Feature:
- Macro: ALU_SEQ_FLAGS_EN
- When defined:
  - Adds output port flags [3:0] = {zero, carry, overflow, negative}, registered with z and reset to 0.
  - zero: z==0.
  - carry: z[N] for add/inc; borrow (x<y) for sub; 0 for all other ops.
  - overflow: signed N-bit overflow for add/sub/inc; 0 for all other ops.
  - negative: z[N-1].
- When undefined: no flags port and no flag logic. All other behaviour is identical.

Test Plan:
- N=8, reset then add x=0xFF, y=0x01, out_ready=1 -> out_valid=1 one cycle after accept, z=0x0100. With flags: carry=1, zero=0.
- Sub x=3, y=5 -> z=0xFFFE. Compare signed-lt x=0x80, y=0x01 -> z=0x0001. Compare eq x=y=0x5A -> z=0x0001.
- Multiply x=200, y=200 -> in_ready=0 for 8 cycles, out_valid 9 cycles after accept, z=0x9C40. in_valid pulses during BUSY are ignored.
- Rotate-left x=0x81, y=1 -> z=0x0003. Shift-left x=0x01, y=9 -> z=0x0000. Rotate-right x=0x01, y=9 -> z=0x0080.
- Backpressure: out_ready=0 for 5 cycles in DONE with a new in_valid held high -> z stable, in_ready=0. On out_ready=1 the new op is accepted the same cycle, and its result appears on the next cycle.
- Assert rst_n=0 mid-multiply (cycle 4 of 8) -> z=0, out_valid=0 immediately, in_ready=1 after release, no stale result emitted.
